// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: display-driver signal bundle
//   master: drives enable, lz_suppress, nums (4 bits per digit), points (one per digit)
//   slave : drives seg (active-low, [7]=dp), an (active-low digit selects), frame_done
interface seven_seg_scan_driver_if #(parameter int DIGITS = 4);
  logic enable;
  logic lz_suppress;
  logic [4*DIGITS-1:0] nums;
  logic [DIGITS-1:0] points;
  logic [7:0] seg;
  logic [DIGITS-1:0] an;
  logic frame_done;
  modport master(output enable, lz_suppress, nums, points, input seg, an, frame_done);
  modport slave(input enable, lz_suppress, nums, points, output seg, an, frame_done);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed seven-segment scanner with dead time and leading-zero blanking
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seven_seg_scan_driver_if (enable, lz_suppress, nums, points in; seg, an, frame_done out)
module seven_seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input logic clk,
  input logic rst_n,
  seven_seg_scan_driver_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic en_q, en_d;
  logic [4*DIGITS-1:0] nums_q, nums_d;
  logic [DIGITS-1:0] points_q, points_d;
  logic lz_q, lz_d;
  logic [7:0] seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic frame_done_q, frame_done_d;
  logic run, start, last_slot, wrap, take, show, z;
  logic [DIGITS-1:0] supp;
  logic [3:0] code;
  function automatic logic [6:0] dec7(input logic [3:0] c);
    case (c)
      4'd0: dec7 = 7'b1000000;
      4'd1: dec7 = 7'b1111001;
      4'd2: dec7 = 7'b0100100;
      4'd3: dec7 = 7'b0110000;
      4'd4: dec7 = 7'b0011001;
      4'd5: dec7 = 7'b0010010;
      4'd6: dec7 = 7'b0000010;
      4'd7: dec7 = 7'b1111000;
      4'd8: dec7 = 7'b0000000;
      4'd9: dec7 = 7'b0010000;
      4'd10: dec7 = 7'b0001001;
      4'd11: dec7 = 7'b0000110;
      4'd12: dec7 = 7'b1000111;
      4'd13: dec7 = 7'b1000000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction
  always_comb begin
    // the first enabled cycle (en_q still low) only snapshots; counting starts the cycle after
    run = bus.enable && en_q;
    start = bus.enable && !en_q;
    last_slot = cnt_q == CW'(CLK_DIV - 1);
    wrap = run && last_slot && idx_q == IW'(DIGITS - 1);
    take = start || wrap;
    en_d = bus.enable;
    cnt_d = run && !last_slot ? cnt_q + 1'b1 : '0;
    idx_d = !run || wrap ? '0 : last_slot ? idx_q + 1'b1 : idx_q;
    nums_d = take ? bus.nums : nums_q;
    points_d = take ? bus.points : points_q;
    lz_d = take ? bus.lz_suppress : lz_q;
    // a digit is blanked when it and every digit above it are zero; digit 0 always shows
    z = lz_q;
    supp = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z && nums_q[4*i +: 4] == 4'd0;
      supp[i] = z;
    end
    code = supp[idx_q] ? 4'hF : nums_q[{idx_q, 2'b00} +: 4];
    show = run && cnt_q >= CW'(BLANK_CYCLES);
    an_d = show ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d = show ? {~points_q[idx_q], dec7(code)} : 8'hFF;
    frame_done_d = wrap;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      en_q <= 1'b0;
      nums_q <= '1;
      points_q <= '0;
      lz_q <= 1'b0;
      seg_q <= 8'hFF;
      an_q <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      en_q <= en_d;
      nums_q <= nums_d;
      points_q <= points_d;
      lz_q <= lz_d;
      seg_q <= seg_d;
      an_q <= an_d;
      frame_done_q <= frame_done_d;
    end
  assign bus.seg = seg_q;
  assign bus.an = an_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: timeline-model checker plus directed literal checks for the scan driver
module tb_seven_seg_scan_driver;
  localparam int DIGITS = 4, CLK_DIV = 10, BLANK = 2, FRAME = DIGITS * CLK_DIV;
  logic clk, rst_n;
  int passed = 0, total = 0;
  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();
  seven_seg_scan_driver_if #(.DIGITS(1)) bus1 ();
  seven_seg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  seven_seg_scan_driver #(.DIGITS(1), .CLK_DIV(3), .BLANK_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  initial clk = 0;
  always #5 clk = ~clk;
  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h89, 8'h86, 8'hC7, 8'hC0, 8'hFF, 8'hFF};
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask
  // position p counts enabled cycles since the frame timeline began
  function automatic logic [11:0] model_out(input int p, input logic [15:0] sn, input logic [3:0] sp, input logic sl);
    int d;
    logic [3:0] c;
    d = (p / CLK_DIV) % DIGITS;
    c = 4'((sn >> (4 * d)) & 16'hF);
    if (sl && d > 0 && (sn >> (4 * d)) == 16'h0) c = 4'hF;
    if (p % CLK_DIV < BLANK) return {4'hF, 8'hFF};
    return {~(4'b1 << d), ~sp[d], seg_tbl[c][6:0]};
  endfunction
  logic run_m = 0;
  int p_m = 0;
  logic [15:0] s_nums;
  logic [3:0] s_pts;
  logic s_lz;
  logic [7:0] e_seg = 8'hFF;
  logic [3:0] e_an = 4'hF;
  logic e_fd = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n || !bus.enable) begin
      run_m <= 0;
      p_m <= 0;
      {e_an, e_seg} <= 12'hFFF;
      e_fd <= 0;
    end else if (!run_m) begin
      run_m <= 1;
      p_m <= 0;
      s_nums <= bus.nums;
      s_pts <= bus.points;
      s_lz <= bus.lz_suppress;
      {e_an, e_seg} <= 12'hFFF;
      e_fd <= 0;
    end else begin
      {e_an, e_seg} <= model_out(p_m, s_nums, s_pts, s_lz);
      e_fd <= p_m % FRAME == FRAME - 1;
      p_m <= p_m + 1;
      if ((p_m + 1) % FRAME == 0) begin
        s_nums <= bus.nums;
        s_pts <= bus.points;
        s_lz <= bus.lz_suppress;
      end
    end
  always @(negedge clk) begin
    chk("model_an", 32'(bus.an), 32'(e_an));
    chk("model_seg", 32'(bus.seg), 32'(e_seg));
    chk("model_fd", 32'(bus.frame_done), 32'(e_fd));
  end
  int gap1 = 0;
  logic seen1 = 0;
  always @(negedge clk)
    if (!rst_n) begin
      gap1 <= 0;
      seen1 <= 0;
    end else if (bus1.frame_done) begin
      if (seen1) chk("d1_fd_period", 32'(gap1 + 1), 32'd3);
      gap1 <= 0;
      seen1 <= 1;
    end else gap1 <= gap1 + 1;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic lit(input string name, input logic [3:0] an, input logic [7:0] seg);
    chk({name, "_an"}, 32'(bus.an), 32'(an));
    chk({name, "_seg"}, 32'(bus.seg), 32'(seg));
  endtask
  logic [7:0] code_lit [6] = '{8'h89, 8'h86, 8'hC7, 8'hC0, 8'hFF, 8'hFF};
  initial begin
    rst_n = 0;
    bus.enable = 0; bus.lz_suppress = 0; bus.nums = '0; bus.points = '0;
    bus1.enable = 0; bus1.lz_suppress = 0; bus1.nums = 4'h5; bus1.points = 1'b0;
    step(2);
    lit("reset", 4'hF, 8'hFF);
    chk("reset_fd", 32'(bus.frame_done), 32'd0);
    rst_n = 1;
    step(1);
    bus1.enable = 1;
    bus.nums = 16'h4321; bus.points = 4'b0100; bus.enable = 1;
    step(4);  lit("d0", 4'hE, 8'hF9);
    step(10); lit("d1", 4'hD, 8'hA4);
    step(10); lit("d2_dp", 4'hB, 8'h30);
    step(10); lit("d3", 4'h7, 8'h99);
    step(7);  chk("frame_done", 32'(bus.frame_done), 32'd1);
    bus.nums = 16'h0070; bus.lz_suppress = 1; bus.points = 4'b0000;
    step(4);  lit("old_frame_d0", 4'hE, 8'hF9);
    step(39); lit("lz_d0", 4'hE, 8'hC0);
    step(10); lit("lz_d1", 4'hD, 8'hF8);
    step(10); lit("lz_d2", 4'hB, 8'hFF);
    step(10); lit("lz_d3", 4'h7, 8'hFF);
    bus.lz_suppress = 0;
    step(40); lit("nolz_d3", 4'h7, 8'hC0);
    bus.enable = 0;
    step(1);  lit("disable", 4'hF, 8'hFF);
    for (int c = 10; c < 16; c++) begin
      bus.nums = 16'(c);
      bus.enable = 1;
      step(3); lit("reen_blank", 4'hF, 8'hFF);
      step(1); lit($sformatf("code%0d", c), 4'hE, code_lit[c-10]);
      bus.enable = 0;
      step(1);
    end
    bus.nums = 16'h4321;
    bus.enable = 1;
    step(20);
    #2 rst_n = 0;
    #1 lit("async_rst", 4'hF, 8'hFF);
    chk("async_rst_fd", 32'(bus.frame_done), 32'd0);
    step(3);
    rst_n = 1;
    step(45);
    chk("d1_an", 32'(bus1.an), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
